// File: rtl/banked_dram_stream.sv
// banked_dram_stream: 2**SEL_W banks of 2**BANK_AW words, with a random
// read/write port and an auto-incrementing stream-write engine.
// Optional macro BANKED_DRAM_OUT_REG_EN adds an output register stage
// (read latency 2 instead of 1).
module banked_dram_stream #(
  parameter int DATA_W  = 8,
  parameter int BANK_AW = 16,
  parameter int SEL_W   = 2,
  localparam int ADDR_W    = BANK_AW + SEL_W,
  localparam int NUM_BANKS = 2 ** SEL_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  input  logic              rden,
  output logic              ready,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  input  logic              s_start,
  input  logic [ADDR_W-1:0] s_base,
  input  logic [ADDR_W:0]   s_len,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              s_busy,
  output logic              s_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  ptr;
  logic [ADDR_W:0]    cnt;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               rd_req;
  logic [SEL_W-1:0]   sel;
  logic [BANK_AW-1:0] lo;

  logic [SEL_W-1:0]   sel_r;
  logic               rd_v1;
  logic [DATA_W-1:0]  q1;
  logic [DATA_W-1:0]  bank_dout [NUM_BANKS];

  assign s_busy  = (state != IDLE);
  assign ready   = !s_busy;
  assign s_ready = (state == RUN);
  assign s_done  = (state == DONE);

  // Random port is only honoured in IDLE; reads never come from the stream engine.
  assign rd_req = rden && (state == IDLE);

  // Memory access mux: the stream engine owns the array while busy.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = address;
    mem_wdata = data;
    if (state == RUN) begin
      mem_we    = s_valid;
      mem_addr  = ptr;
      mem_wdata = s_data;
    end else if (state == IDLE) begin
      mem_we = wren;
    end
  end

  assign sel = mem_addr[ADDR_W-1:BANK_AW];
  assign lo  = mem_addr[BANK_AW-1:0];

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    logic [DATA_W-1:0] ram [2**BANK_AW];
    logic [DATA_W-1:0] dout;
    logic              bank_we;
    logic              bank_rd;

    assign bank_we = mem_we && (sel == SEL_W'(k));
    assign bank_rd = rd_req && (sel == SEL_W'(k));

    // Bank array write; contents are never reset.
    always_ff @(posedge clock) begin
      if (bank_we) ram[lo] <= mem_wdata;
    end

    // Read register updates only on a read of this bank, so q holds between
    // reads; a same-cycle write to the read address is forwarded (write-first).
    always_ff @(posedge clock or posedge reset) begin
      if (reset)        dout <= '0;
      else if (bank_rd) dout <= bank_we ? mem_wdata : ram[lo];
    end

    assign bank_dout[k] = dout;
  end

  // Bank select and valid pipelined alongside the RAM read latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_r <= '0;
      rd_v1 <= 1'b0;
    end else begin
      rd_v1 <= rd_req;
      if (rd_req) sel_r <= sel;
    end
  end

  assign q1 = bank_dout[sel_r];

`ifdef BANKED_DRAM_OUT_REG_EN
  logic [DATA_W-1:0] q_r;
  logic              qv_r;

  // Extra output stage; q holds between reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_r  <= '0;
      qv_r <= 1'b0;
    end else begin
      qv_r <= rd_v1;
      if (rd_v1) q_r <= q1;
    end
  end

  assign q       = q_r;
  assign q_valid = qv_r;
`else
  assign q       = q1;
  assign q_valid = rd_v1;
`endif

  // Stream engine state, pointer and remaining-word count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && s_start) begin
        ptr <= s_base;
        cnt <= s_len;
      end else if (state == RUN && s_valid) begin
        ptr <= ptr + ADDR_W'(1);
        cnt <= cnt - (ADDR_W + 1)'(1);
      end
    end
  end

  // Next-state logic for the stream engine.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (s_start) state_nx = (s_len == '0) ? DONE : RUN;
      RUN:  if (s_valid && cnt == (ADDR_W + 1)'(1)) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_banked_dram_stream.sv
module tb_banked_dram_stream;
  localparam int DW = 8;
  localparam int BAW = 16;
  localparam int SW = 2;
  localparam int AW = BAW + SW;
`ifdef BANKED_DRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clock, reset;
  logic [AW-1:0] address;
  logic [DW-1:0] data;
  logic          wren, rden, ready;
  logic [DW-1:0] q;
  logic          q_valid;
  logic          s_start;
  logic [AW-1:0] s_base;
  logic [AW:0]   s_len;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready, s_busy, s_done;

  banked_dram_stream #(.DATA_W(DW), .BANK_AW(BAW), .SEL_W(SW)) dut (
    .clock(clock), .reset(reset), .address(address), .data(data),
    .wren(wren), .rden(rden), .ready(ready), .q(q), .q_valid(q_valid),
    .s_start(s_start), .s_base(s_base), .s_len(s_len), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_busy(s_busy), .s_done(s_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
    int unsigned   a;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mem_m [int unsigned];
  int unsigned   known[$];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every q_valid pulse must match the oldest outstanding read, on time.
  always @(negedge clock) begin
    if (!reset && q_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_q_valid: got q=%0h with no read outstanding (cycle %0d)", q, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (q !== e.d || cyc != e.due) begin
          n_err++;
          $display("FAIL read_%0h: got q=%0h at cycle %0d, expected %0h at cycle %0d",
                   e.a, q, cyc, e.d, e.due);
        end
      end
    end
    if (sb.size() > 0 && sb[0].due < cyc) begin
      n_cmp++;
      n_err++;
      $display("FAIL missing_q_valid_%0h: got none, expected %0h by cycle %0d", sb[0].a, sb[0].d, sb[0].due);
      void'(sb.pop_front());
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got no finish, expected end of test");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic access(input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] d, input bit rd);
    address = a; data = d; wren = wr; rden = rd;
    if (wr) begin
      mem_m[a] = d;
      known.push_back(a);
    end
    if (rd) sb.push_back('{mem_m[a], cyc + LAT, a});
    tick();
    wren = 1'b0; rden = 1'b0;
  endtask

  task automatic drain();
    repeat (LAT + 2) tick();
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  // vpct<0 selects the fixed 1,0,1,0,... valid pattern; abort_at>=0 resets after that many handshakes.
  task automatic stream(input logic [AW-1:0] base, input int unsigned len, input int vpct,
                        input int abort_at, input bit intrude);
    logic [AW-1:0] p;
    int unsigned   rem;
    int            hs, guard;
    bit            v;
    s_base = base; s_len = (AW + 1)'(len); s_start = 1'b1;
    tick();
    s_start = 1'b0;
    if (len == 0) begin
      chk("len0_done", s_done, 1);
      chk("len0_busy", s_busy, 1);
      chk("len0_sready", s_ready, 0);
      tick();
      chk("len0_done_clear", s_done, 0);
      chk("len0_idle", s_busy, 0);
      return;
    end
    p = base; rem = len; hs = 0; guard = 0;
    while (rem > 0 && guard < 2000) begin
      chk("run_busy", s_busy, 1);
      chk("run_sready", s_ready, 1);
      chk("run_no_done", s_done, 0);
      chk("run_ready_low", ready, 0);
      if (abort_at >= 0 && hs == abort_at) begin
        reset = 1'b1; s_valid = 1'b0;
        #1;
        chk("abort_busy", s_busy, 0);
        chk("abort_no_done", s_done, 0);
        chk("abort_qv", q_valid, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("abort_idle", s_busy, 0);
        chk("abort_no_done_after", s_done, 0);
        return;
      end
      v = (vpct < 0) ? !guard[0] : ($urandom_range(99) < vpct);
      s_valid = v;
      s_data = DW'($urandom);
      if (intrude) begin
        wren = 1'b1; rden = 1'b1; address = AW'('h20000); data = 8'h77;
      end
      if (v) begin
        mem_m[p] = s_data;
        known.push_back(p);
        p = p + 1'b1;
        rem--;
        hs++;
      end
      tick();
      s_valid = 1'b0; wren = 1'b0; rden = 1'b0;
      guard++;
    end
    chk("stream_bounded", (guard < 2000) ? 1 : 0, 1);
    chk("end_done", s_done, 1);
    chk("end_busy", s_busy, 1);
    chk("end_sready", s_ready, 0);
    tick();
    chk("post_done_clear", s_done, 0);
    chk("post_idle", s_busy, 0);
    chk("post_ready", ready, 1);
  endtask

  initial begin
    reset = 1'b1; address = '0; data = '0; wren = 1'b0; rden = 1'b0;
    s_start = 1'b0; s_base = '0; s_len = '0; s_data = '0; s_valid = 1'b0;
    tick(); tick();
    chk("rst_q", q, 0);
    chk("rst_qv", q_valid, 0);
    chk("rst_sready", s_ready, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_ready", ready, 1);
    reset = 1'b0;
    tick();

    // Bank isolation: same low address in banks 0 and 1.
    access(AW'('h00010), 1, 8'hA5, 0);
    access(AW'('h10010), 1, 8'h3C, 0);
    access(AW'('h00010), 0, 8'h00, 1);
    access(AW'('h10010), 0, 8'h00, 1);
    drain();

    // Stream across the bank 0/1 boundary, s_valid always high.
    stream(AW'('h0FFFE), 4, 100, -1, 0);
    for (int unsigned i = 0; i < 4; i++) access(AW'('h0FFFE + i), 0, 8'h00, 1);
    drain();

    // Toggling s_valid: exactly three words written, the fourth location untouched.
    access(AW'('h01003), 1, 8'hEE, 0);
    stream(AW'('h01000), 3, -1, -1, 0);
    for (int unsigned i = 0; i < 4; i++) access(AW'('h01000 + i), 0, 8'h00, 1);
    drain();

    // Address wrap from the top of bank 3 to address 0.
    stream(AW'('h3FFFF), 2, 100, -1, 0);
    access(AW'('h3FFFF), 0, 8'h00, 1);
    access(AW'('h00000), 0, 8'h00, 1);
    drain();

    // Random-port writes and reads are ignored while the engine is busy.
    access(AW'('h20000), 1, 8'h11, 0);
    stream(AW'('h05000), 3, 100, -1, 1);
    access(AW'('h20000), 0, 8'h00, 1);
    drain();

    // Zero-length fill writes nothing.
    access(AW'('h06000), 1, 8'h5A, 0);
    stream(AW'('h06000), 0, 100, -1, 0);
    access(AW'('h06000), 0, 8'h00, 1);
    drain();

    // Reset after two of five words; the two written words survive.
    stream(AW'('h07000), 5, 100, 2, 0);
    access(AW'('h07000), 0, 8'h00, 1);
    access(AW'('h07001), 0, 8'h00, 1);
    drain();

    // Randomized mix of writes, reads, write-first collisions and fills.
    for (int it = 0; it < 80; it++) begin
      int unsigned   r;
      logic [AW-1:0] a;
      r = $urandom_range(3);
      a = AW'($urandom);
      case (r)
        0: access(a, 1, DW'($urandom), 0);
        1: access(AW'(known[$urandom_range(known.size() - 1)]), 0, 8'h00, 1);
        2: access(a, 1, DW'($urandom), 1);
        default: begin
          drain();
          stream(a, $urandom_range(1, 6), 60, -1, 0);
        end
      endcase
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/banked_dram_stream.md
Name: banked_dram_stream

Overview:
- Parametrised successor to the fixed 4×64K×8 banked RAM.
- 2**SEL_W banks of 2**BANK_AW words each. Upper address bits pick the bank; the per-bank write-enable is decoded from them; the read data is muxed with a bank select that is pipelined to match the RAM latency.
- Adds an auto-incrementing stream-write engine with a valid/ready handshake. The UART image loader uses it to fill frame memory without driving addresses.
- Sits between the UART receiver/loader and the downsampling datapath.

Parameters:
- DATA_W, 8, word width in bits.
- BANK_AW, 16, address bits per bank. Bank depth is 2**BANK_AW.
- SEL_W, 2, bank-select bits. NUM_BANKS = 2**SEL_W. Total address width ADDR_W = BANK_AW+SEL_W.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- address  in  ADDR_W  random-port address; [ADDR_W-1:BANK_AW] selects the bank.
- data  in  DATA_W  random-port write data.
- wren  in  1  random-port write enable.
- rden  in  1  random-port read request.
- ready  out  1  random port accepted; equals !s_busy.
- q  out  DATA_W  read data.
- q_valid  out  1  one-cycle pulse when q carries new read data.
- s_start  in  1  start a stream fill; sampled only in IDLE.
- s_base  in  ADDR_W  first stream address, latched on start.
- s_len  in  ADDR_W+1  number of words to write, latched on start.
- s_data  in  DATA_W  stream write data.
- s_valid  in  1  stream data valid.
- s_ready  out  1  engine accepts s_data this cycle.
- s_busy  out  1  engine owns the memory.
- s_done  out  1  one-cycle pulse at end of fill.

Behaviour:
- Memory:
  - Inferred synchronous single-port array per bank.
  - Write occurs at the clock edge where the bank's wren is high.
  - Read data is available from the RAM one cycle after the address.
  - Contents are not reset.
- Bank decode:
  - Exactly one bank write-enable may be high.
  - wren_k = we && (sel == k).
  - An out-of-range sel is impossible by construction.
- Read path:
  - When rden && ready, the bank select is registered.
  - q is the selected bank's output, registered; q_valid=1 one cycle after the request (latency 1).
  - q holds its value when no read occurs.
  - rden and wren together at the same address: write-first. q returns the new data.
- Random port while s_busy=1: wren and rden are ignored; no write, no q_valid.
- FSM states IDLE, RUN, DONE:
  - IDLE: s_ready=0, s_busy=0.
    - On s_start, latch ptr<=s_base and cnt<=s_len.
    - If s_len==0, go to DONE; otherwise go to RUN.
    - A random access in the same cycle as s_start completes normally.
  - RUN: s_busy=1, s_ready=1.
    - Each cycle with s_valid=1: write s_data at ptr, ptr<=ptr+1, cnt<=cnt-1.
    - s_valid=0 stalls with no change.
    - When cnt==1 and the handshake occurs, go to DONE.
  - DONE: s_done=1 for one cycle, s_busy=1, s_ready=0. Go to IDLE next cycle.
  - s_start in RUN or DONE is ignored.
- Wrap-around:
  - ptr is ADDR_W bits and wraps from 2**ADDR_W-1 to 0, crossing banks seamlessly.
  - s_len up to 2**ADDR_W is legal.
- Reset:
  - Reset values: q=0, q_valid=0, s_ready=0, s_busy=0, s_done=0, ready=1, FSM=IDLE, ptr=0, cnt=0.
  - Reset asserted mid-RUN aborts the fill immediately. Words already written remain, and no s_done is issued.

Optional Feature:
- Macro: BANKED_DRAM_OUT_REG_EN.
- Defined: an extra output register stage is added. q and q_valid latency becomes 2 cycles, and the bank select is pipelined 2 deep. Throughput is still one read per cycle.
- Undefined: latency is 1 as described above.

Test Plan:
- Reset, then write 0xA5 at 0x00010 and 0x3C at 0x10010, then read both. Required: q=0xA5 then 0x3C, each with q_valid 1 cycle after rden, proving bank isolation.
- s_start with s_base=0x0FFFE, s_len=4 and data 1,2,3,4 with s_valid always 1. Required: s_done exactly 4 cycles after entering RUN. Reads of 0x0FFFE..0x10001 return 1..4 across the bank 0/1 boundary.
- s_len=3 with s_valid toggling 1,0,1,0,1. Required: 3 writes only, and s_done on the cycle after the third handshake.
- s_base=0x3FFFF, s_len=2. Required: data written to 0x3FFFF and 0x00000 (address wrap).
- During RUN, drive wren=1 to 0x20000 with 0x77. Required: ready=0, and that location is unchanged afterwards. Separately, s_len=0 gives s_done 1 cycle after start with no writes.
- Assert reset after 2 of 5 stream words. Required: s_busy=0 and s_done never pulses; the first 2 words read back correctly. With BANKED_DRAM_OUT_REG_EN defined, q_valid arrives 2 cycles after rden.
